// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one fixed-latency FP add/sub pipeline between NUM_REQ requesters.
// Tags {valid, id} ride alongside the pipeline so each result is steered back to its owner.
module fp_add_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int PIPE_LAT = 4,
    parameter int ID_W     = $clog2(NUM_REQ),
    localparam int CNT_W   = $clog2(PIPE_LAT + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [32*NUM_REQ-1:0]  req_a,
    input  logic [32*NUM_REQ-1:0]  req_b,
    input  logic [NUM_REQ-1:0]     req_sub,
    input  logic                   hold,
    output logic                   pipe_issue,
    output logic [31:0]            pipe_a,
    output logic [31:0]            pipe_b,
    output logic                   pipe_sub,
    input  logic [31:0]            pipe_result,
    output logic [NUM_REQ-1:0]     res_valid,
    output logic [31:0]            res_data,
    output logic [CNT_W-1:0]       inflight,
    output logic                   idle
);

    logic [ID_W-1:0]                rr_ptr;
    logic [ID_W-1:0]                grant_id;
    logic [ID_W-1:0]                cand;
    logic                           grant_found;
    logic                           grant;
    logic [PIPE_LAT-1:0]            tag_v;
    logic [PIPE_LAT-1:0][ID_W-1:0]  tag_id;
    logic                           retire;
    logic [ID_W-1:0]                last_id;

    // Search starts one past the last winner and wraps, so the last winner has lowest priority.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    assign grant = grant_found && !hold && !rst;

    always_comb begin
        req_ready  = '0;
        pipe_issue = grant;
        pipe_a     = '0;
        pipe_b     = '0;
        pipe_sub   = 1'b0;
        if (grant) begin
            req_ready[grant_id] = 1'b1;
            pipe_sub            = req_sub[grant_id];
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_id == ID_W'(i)) begin
                    pipe_a = req_a[32*i +: 32];
                    pipe_b = req_b[32*i +: 32];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v[0]  <= pipe_issue;
            tag_id[0] <= grant_id;
            for (int i = 1; i < PIPE_LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    assign retire  = tag_v[PIPE_LAT-1];
    assign last_id = tag_id[PIPE_LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= ID_W'(NUM_REQ - 1);
            res_valid <= '0;
            res_data  <= '0;
            inflight  <= '0;
        end else begin
            if (grant) begin
                rr_ptr <= grant_id;
            end
            if (retire) begin
                res_valid <= NUM_REQ'(1) << last_id;
                res_data  <= pipe_result;
            end else begin
                res_valid <= '0;
            end
            case ({pipe_issue, retire})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    assign idle = (inflight == '0) && !(|req_valid);

endmodule
